// File: rtl/ppm_rx.sv
// PPM receiver: synchronizes the pin, times edge-to-edge gaps in microseconds, and frames
// NUM_CH channel pulses between sync gaps, with optional 3-sample median and failsafe.
module ppm_rx #(
    parameter int NUM_CH     = 6,
    parameter int CLK_PER_US = 50,
    parameter int SYNC_US    = 5000,
    parameter int LOW_US     = 1000,
    parameter int SPAN_US    = 1000,
    parameter int OUT_W      = 12,
    parameter int MEDIAN     = 1,
    parameter int RISE_EDGE  = 1,
    parameter int TIMEOUT_US = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ppm,
    output logic [OUT_W-1:0] ch_out [0:NUM_CH-1],
    output logic             frame_done,
    output logic             failsafe,
    output logic [7:0]       err_cnt
);

    localparam int CHI_W = $clog2(NUM_CH + 1);
    localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

    localparam logic             IDLE       = (RISE_EDGE == 0);
    localparam logic [PRE_W-1:0] PRE_MAX    = PRE_W'(CLK_PER_US - 1);
    localparam logic [16:0]      SYNC_TH    = 17'(SYNC_US);
    localparam logic [16:0]      LOW_TH     = 17'(LOW_US);
    localparam logic [16:0]      HIGH_TH    = 17'(LOW_US + SPAN_US);
    localparam logic [16:0]      TIMEOUT_TH = 17'(TIMEOUT_US);
    localparam logic [OUT_W-1:0] SPAN_MAX   = OUT_W'(SPAN_US - 1);
    localparam logic [CHI_W-1:0] CHI_FULL   = CHI_W'(NUM_CH);

    typedef enum logic {HUNT, RECV} state_t;

    function automatic logic [OUT_W-1:0] med3(input logic [OUT_W-1:0] a,
                                              input logic [OUT_W-1:0] b,
                                              input logic [OUT_W-1:0] c);
        logic [OUT_W-1:0] lo;
        logic [OUT_W-1:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return (c < lo) ? lo : ((c > hi) ? hi : c);
    endfunction

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0]      us_cnt_q, us_cnt_d;
    state_t           state_q, state_d;
    logic [CHI_W-1:0] chi_q, chi_d;
    logic [OUT_W-1:0] stage_q [0:NUM_CH-1];
    logic [OUT_W-1:0] stage_d [0:NUM_CH-1];
    logic [OUT_W-1:0] hist1_q [0:NUM_CH-1];
    logic [OUT_W-1:0] hist1_d [0:NUM_CH-1];
    logic [OUT_W-1:0] hist2_q [0:NUM_CH-1];
    logic [OUT_W-1:0] hist2_d [0:NUM_CH-1];
    logic [OUT_W-1:0] ch_q    [0:NUM_CH-1];
    logic [OUT_W-1:0] ch_d    [0:NUM_CH-1];
    logic             frame_done_q, frame_done_d;
    logic             failsafe_q, failsafe_d;
    logic [7:0]       err_q, err_d;
    logic [16:0]      loss_q, loss_d;

    logic             edge_act;
    logic             tick;
    logic             is_sync;
    logic             commit;
    logic             err_inc;
    logic [16:0]      interval;
    logic [OUT_W-1:0] slot_val;

    assign edge_act = (sync2_q != prev_q) && (sync2_q != IDLE);
    assign tick     = (pre_q == PRE_MAX) && !edge_act;
    assign interval = {1'b0, us_cnt_q};
    assign is_sync  = (interval >= SYNC_TH);

    // An edge restarts the microsecond timebase and swallows any tick due that cycle.
    always_comb begin
        sync1_d  = ppm;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        pre_d    = pre_q;
        us_cnt_d = us_cnt_q;
        if (edge_act) begin
            pre_d    = '0;
            us_cnt_d = '0;
        end else begin
            pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
            if (tick && us_cnt_q != 16'hFFFF) begin
                us_cnt_d = us_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        if (interval < LOW_TH) begin
            slot_val = '0;
        end else if (interval >= HIGH_TH) begin
            slot_val = SPAN_MAX;
        end else begin
            slot_val = OUT_W'(interval - LOW_TH);
        end
    end

    always_comb begin
        state_d      = state_q;
        chi_d        = chi_q;
        stage_d      = stage_q;
        hist1_d      = hist1_q;
        hist2_d      = hist2_q;
        ch_d         = ch_q;
        frame_done_d = 1'b0;
        commit       = 1'b0;
        err_inc      = 1'b0;
        if (edge_act) begin
            case (state_q)
                HUNT: begin
                    if (is_sync) begin
                        state_d = RECV;
                        chi_d   = '0;
                    end
                end
                RECV: begin
                    if (!is_sync) begin
                        if (chi_q < CHI_FULL) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (chi_q == CHI_W'(i)) begin
                                    stage_d[i] = slot_val;
                                end
                            end
                            chi_d = chi_q + 1'b1;
                        end else begin
                            err_inc = 1'b1;
                            state_d = HUNT;
                            chi_d   = '0;
                        end
                    end else if (chi_q == CHI_FULL) begin
                        commit = 1'b1;
                        chi_d  = '0;
                    end else begin
                        err_inc = 1'b1;
                        chi_d   = '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            stage_d[i] = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        // All channels and their histories move together on a commit.
        if (commit) begin
            frame_done_d = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                hist2_d[i] = hist1_q[i];
                hist1_d[i] = stage_q[i];
                ch_d[i]    = (MEDIAN != 0) ? med3(stage_q[i], hist1_q[i], hist2_q[i])
                                           : stage_q[i];
            end
        end
    end

    always_comb begin
        err_d      = err_q;
        loss_d     = loss_q;
        failsafe_d = failsafe_q;
        if (err_inc && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
        if (commit) begin
            loss_d     = '0;
            failsafe_d = 1'b0;
        end else begin
            if (tick && loss_q != 17'h1FFFF) begin
                loss_d = loss_q + 17'd1;
            end
            if (loss_d >= TIMEOUT_TH) begin
                failsafe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q      <= IDLE;
            sync2_q      <= IDLE;
            prev_q       <= IDLE;
            pre_q        <= '0;
            us_cnt_q     <= '0;
            state_q      <= HUNT;
            chi_q        <= '0;
            frame_done_q <= 1'b0;
            failsafe_q   <= 1'b1;
            err_q        <= '0;
            loss_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                stage_q[i] <= '0;
                hist1_q[i] <= '0;
                hist2_q[i] <= '0;
                ch_q[i]    <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            pre_q        <= pre_d;
            us_cnt_q     <= us_cnt_d;
            state_q      <= state_d;
            chi_q        <= chi_d;
            frame_done_q <= frame_done_d;
            failsafe_q   <= failsafe_d;
            err_q        <= err_d;
            loss_q       <= loss_d;
            stage_q      <= stage_d;
            hist1_q      <= hist1_d;
            hist2_q      <= hist2_d;
            ch_q         <= ch_d;
        end
    end

    assign ch_out     = ch_q;
    assign frame_done = frame_done_q;
    assign failsafe   = failsafe_q;
    assign err_cnt    = err_q;

endmodule

// File: tb/tb_ppm_rx.sv
// Bench for ppm_rx: directed frames with literal expectations, then random frames, all
// compared every cycle against a gap-based frame model of the receiver.
module tb_ppm_rx;

    localparam int NUM_CH     = 6;
    localparam int CLK_PER_US = 1;
    localparam int SYNC_US    = 600;
    localparam int LOW_US     = 100;
    localparam int SPAN_US    = 100;
    localparam int OUT_W      = 12;
    localparam int MEDIAN     = 1;
    localparam int RISE_EDGE  = 1;
    localparam int TIMEOUT_US = 3000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             ppm = 1'b0;
    logic [OUT_W-1:0] ch_out [0:NUM_CH-1];
    logic             frame_done;
    logic             failsafe;
    logic [7:0]       err_cnt;

    int checks   = 0;
    int failures = 0;

    ppm_rx #(
        .NUM_CH(NUM_CH), .CLK_PER_US(CLK_PER_US), .SYNC_US(SYNC_US), .LOW_US(LOW_US),
        .SPAN_US(SPAN_US), .OUT_W(OUT_W), .MEDIAN(MEDIAN), .RISE_EDGE(RISE_EDGE),
        .TIMEOUT_US(TIMEOUT_US)
    ) dut (
        .clk(clk), .rst(rst), .ppm(ppm), .ch_out(ch_out),
        .frame_done(frame_done), .failsafe(failsafe), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Model state: gaps are measured in ticks (one per clock at CLK_PER_US=1, none on an
    // edge clock), and a pin rise sampled at clock n is acted on at clock n+2.
    int  cyc = 0;
    bit  model_valid = 1'b0;
    int  last_edge, exp_err, exp_loss;
    bit  exp_fd, exp_fs, synced, prev_pin, edge_now;
    int  exp_ch [NUM_CH];
    int  hist1 [NUM_CH];
    int  hist2 [NUM_CH];
    int  staged [$];
    int  pend [$];
    int  fd_seen = 0;
    int  base_iv [NUM_CH];

    function automatic int clampSlot(input int iv);
        if (iv < LOW_US) return 0;
        if (iv >= LOW_US + SPAN_US) return SPAN_US - 1;
        return (iv - LOW_US) % (1 << OUT_W);
    endfunction

    function automatic int median3(input int a, input int b, input int c);
        int q [$];
        q = '{a, b, c};
        q.sort();
        return q[1];
    endfunction

    task automatic modelEdge(input int n);
        int iv;
        bit sync_gap;
        iv = n - last_edge - 1;
        if (iv > 65535) iv = 65535;
        last_edge = n;
        sync_gap = (iv >= SYNC_US);
        if (!synced) begin
            if (sync_gap) begin
                synced = 1'b1;
                staged.delete();
            end
        end else if (!sync_gap) begin
            if (staged.size() < NUM_CH) begin
                staged.push_back(clampSlot(iv));
            end else begin
                if (exp_err < 255) exp_err++;
                synced = 1'b0;
                staged.delete();
            end
        end else begin
            if (staged.size() == NUM_CH) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    exp_ch[i] = (MEDIAN != 0) ? median3(staged[i], hist1[i], hist2[i]) : staged[i];
                    hist2[i]  = hist1[i];
                    hist1[i]  = staged[i];
                end
                exp_fd   = 1'b1;
                exp_loss = 0;
                exp_fs   = 1'b0;
            end else begin
                if (exp_err < 255) exp_err++;
            end
            staged.delete();
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        exp_fd = 1'b0;
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                exp_ch[i] = 0;
                hist1[i]  = 0;
                hist2[i]  = 0;
            end
            staged.delete();
            pend.delete();
            exp_fs    = 1'b1;
            exp_err   = 0;
            exp_loss  = 0;
            synced    = 1'b0;
            prev_pin  = 1'b0;
            last_edge = cyc;
        end else begin
            edge_now = 1'b0;
            if (pend.size() > 0 && pend[0] == cyc) begin
                edge_now = 1'b1;
                void'(pend.pop_front());
            end
            if (ppm && !prev_pin) pend.push_back(cyc + 2);
            prev_pin = ppm;
            if (edge_now) begin
                modelEdge(cyc);
            end else begin
                if (exp_loss < 131071) exp_loss++;
                if (exp_loss >= TIMEOUT_US) exp_fs = 1'b1;
            end
        end
        model_valid = 1'b1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
                checkOutput($sformatf("ch_out[%0d]", i), int'(ch_out[i]), exp_ch[i]);
            end
            checkOutput("frame_done", int'(frame_done), int'(exp_fd));
            checkOutput("failsafe", int'(failsafe), int'(exp_fs));
            checkOutput("err_cnt", int'(err_cnt), exp_err);
            if (frame_done) fd_seen++;
        end
    end

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Rising edges are spaced iv+1 clocks apart, which the receiver reads as a gap of iv.
    task automatic applyStimulus(input int iv);
        repeat (iv - 3) tick1();
        ppm = 1'b1;
        repeat (4) tick1();
        ppm = 1'b0;
    endtask

    task automatic sendPulses(input int n, input int iv);
        for (int i = 0; i < n; i++) applyStimulus(iv);
    endtask

    task automatic sendFrame(input int ch0_iv, input int sync_iv);
        applyStimulus(ch0_iv);
        for (int i = 1; i < NUM_CH; i++) applyStimulus(base_iv[i]);
        applyStimulus(sync_iv);
    endtask

    function automatic int randPulse();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0: return $urandom_range(10, 99);
            1: begin
                int b [$];
                b = '{99, 100, 199, 200};
                return b[$urandom_range(0, 3)];
            end
            2: return $urandom_range(200, 400);
            default: return $urandom_range(100, 199);
        endcase
    endfunction

    function automatic int randSync();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return 599;
        if (r == 1) return 600;
        return $urandom_range(601, 700);
    endfunction

    initial begin
        #(2_000_000);
        failures++;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        base_iv = '{150, 120, 180, 100, 200, 140};
        rst = 1'b0;
        ppm = 1'b0;
        repeat (3) tick1();
        checkOutput("reset ch_out[0]", int'(ch_out[0]), 0);
        checkOutput("reset failsafe", int'(failsafe), 1);
        checkOutput("reset err_cnt", int'(err_cnt), 0);
        checkOutput("reset frame_done", int'(frame_done), 0);
        rst = 1'b1;

        $display("[TB] three identical frames");
        applyStimulus(650);
        repeat (3) sendFrame(150, 650);
        checkOutput("settle ch0", int'(ch_out[0]), 50);
        checkOutput("settle ch1", int'(ch_out[1]), 20);
        checkOutput("settle ch2", int'(ch_out[2]), 80);
        checkOutput("settle ch3 low edge", int'(ch_out[3]), 0);
        checkOutput("settle ch4 clamp", int'(ch_out[4]), 99);
        checkOutput("settle ch5", int'(ch_out[5]), 40);
        checkOutput("settle frames", fd_seen, 3);
        checkOutput("settle failsafe", int'(failsafe), 0);

        $display("[TB] median frames");
        sendFrame(110, 650);
        sendFrame(190, 650);
        sendFrame(130, 650);
        checkOutput("median ch0", int'(ch_out[0]), 30);
        checkOutput("median ch1", int'(ch_out[1]), 20);
        checkOutput("median frames", fd_seen, 6);

        $display("[TB] short frame");
        sendPulses(5, 150);
        applyStimulus(650);
        checkOutput("short err_cnt", int'(err_cnt), 1);
        checkOutput("short ch0 held", int'(ch_out[0]), 30);
        checkOutput("short no commit", fd_seen, 6);
        sendFrame(150, 650);
        checkOutput("after short ch0", int'(ch_out[0]), 50);
        checkOutput("after short frames", fd_seen, 7);

        $display("[TB] extra pulse");
        sendPulses(7, 150);
        checkOutput("extra err_cnt", int'(err_cnt), 2);
        applyStimulus(650);
        sendFrame(150, 650);
        checkOutput("after extra frames", fd_seen, 8);
        checkOutput("after extra ch0", int'(ch_out[0]), 50);

        $display("[TB] loss of signal");
        repeat (TIMEOUT_US - 2) tick1();
        checkOutput("failsafe one tick early", int'(failsafe), 0);
        tick1();
        checkOutput("failsafe at timeout", int'(failsafe), 1);
        checkOutput("failsafe ch0 held", int'(ch_out[0]), 50);
        applyStimulus(650);
        sendFrame(150, 650);
        checkOutput("failsafe cleared", int'(failsafe), 0);
        checkOutput("recover err_cnt", int'(err_cnt), 3);
        checkOutput("recover frames", fd_seen, 9);

        $display("[TB] reset mid-frame");
        sendPulses(2, 150);
        repeat (50) tick1();
        rst = 1'b0;
        tick1();
        checkOutput("midreset ch0", int'(ch_out[0]), 0);
        checkOutput("midreset failsafe", int'(failsafe), 1);
        checkOutput("midreset err_cnt", int'(err_cnt), 0);
        checkOutput("midreset frame_done", int'(frame_done), 0);
        repeat (2) tick1();
        rst = 1'b1;
        applyStimulus(650);
        sendFrame(150, 650);
        checkOutput("post reset ch0 median", int'(ch_out[0]), 0);
        checkOutput("post reset frames", fd_seen, 10);
        checkOutput("post reset failsafe", int'(failsafe), 0);

        $display("[TB] random frames");
        for (int it = 0; it < 30; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                sendPulses($urandom_range(0, 3), 150);
                rst = 1'b0;
                repeat ($urandom_range(1, 4)) tick1();
                rst = 1'b1;
                applyStimulus(650);
            end else if (kind == 1) begin
                for (int p = $urandom_range(0, NUM_CH - 1); p > 0; p--) applyStimulus(randPulse());
                applyStimulus(randSync());
            end else if (kind == 2) begin
                for (int p = 0; p <= NUM_CH; p++) applyStimulus(randPulse());
                applyStimulus(650);
            end else begin
                for (int p = 0; p < NUM_CH; p++) applyStimulus(randPulse());
                applyStimulus(randSync());
            end
        end
        repeat (10) tick1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ppm_rx.md
PPM_RX -- requirements
Module: ppm_rx

Parameters
REQ-001 The block SHALL expose parameter NUM_CH, default 6, giving channels per frame (1..16).
REQ-002 The block SHALL expose parameter CLK_PER_US, default 50, giving clk cycles per microsecond tick.
REQ-003 The block SHALL expose parameter SYNC_US, default 5000, giving the minimum edge-to-edge gap in microseconds treated as frame sync.
REQ-004 The block SHALL expose parameters LOW_US, default 1000, and SPAN_US, default 1000, giving the valid pulse window.
REQ-005 The block SHALL expose parameter OUT_W, default 12, giving channel output width.
REQ-006 The block SHALL expose parameter MEDIAN, default 1, selecting 3-sample median filtering (1) or raw output (0).
REQ-007 The block SHALL expose parameter RISE_EDGE, default 1, selecting the active edge: rising (1) or falling (0).
REQ-008 The block SHALL expose parameter TIMEOUT_US, default 50000, giving the loss-of-signal failsafe delay.

Interface
REQ-009 clk  input  1  sole clock; all logic is on its rising edge.
REQ-010 rst  input  1  synchronous reset, active-low (0 = reset).
REQ-011 ppm  input  1  asynchronous PPM stream.
REQ-012 ch_out  output  NUM_CH x OUT_W (unpacked [0:NUM_CH-1])  committed channel values.
REQ-013 frame_done  output  1  one-cycle pulse when ch_out is updated.
REQ-014 failsafe  output  1  high while no valid frame has been committed within TIMEOUT_US.
REQ-015 err_cnt  output  8  saturating count of rejected frames.

Function
REQ-016 ppm SHALL pass through a 2-flop synchronizer followed by a 1-flop edge detector; an active edge is flagged 3 cycles after the pin transition.
REQ-017 The prescaler SHALL count 0..CLK_PER_US-1 and SHALL emit a tick on wrap; a 16-bit us_cnt SHALL increment on each tick, saturating at 65535.
REQ-018 On an active edge, interval = us_cnt; us_cnt and the prescaler SHALL clear that cycle, and the edge SHALL take priority over a coincident tick.
REQ-019 FSM states: HUNT and RECV; reset state is HUNT; chi (channel index) SHALL reset to 0.
REQ-020 In HUNT, an edge with interval >= SYNC_US SHALL move the FSM to RECV with chi=0; any other edge SHALL stay in HUNT.
REQ-021 In RECV, an edge with interval < SYNC_US and chi < NUM_CH SHALL store into a staging slot: interval < LOW_US -> 0; interval >= LOW_US+SPAN_US -> SPAN_US-1; otherwise interval-LOW_US, truncated to OUT_W; chi then increments.
REQ-022 In RECV, an edge with interval < SYNC_US and chi == NUM_CH (extra pulse) SHALL increment err_cnt and return the FSM to HUNT.
REQ-023 In RECV, an edge with interval >= SYNC_US and chi == NUM_CH SHALL commit the frame, set chi=0, and keep the FSM in RECV.
REQ-024 In RECV, an edge with interval >= SYNC_US and chi != NUM_CH (short frame) SHALL increment err_cnt, discard staging, set chi=0, and keep the FSM in RECV.
REQ-025 On commit, each channel's history SHALL shift (h2<=h1, h1<=staged); ch_out SHALL be set to median(staged, h1, h2) if MEDIAN=1, else to staged; all channels SHALL update in the same cycle.
REQ-026 frame_done SHALL pulse high for exactly one cycle, in the cycle after the commit edge, coincident with the ch_out update.
REQ-027 ch_out SHALL change only on commit; rejected or partial frames SHALL never alter ch_out or history.
REQ-028 err_cnt SHALL saturate at 255.
REQ-029 A 17-bit loss counter SHALL count ticks since the last commit, saturating; failsafe SHALL assert when it reaches TIMEOUT_US.
REQ-030 A commit SHALL clear the loss counter and deassert failsafe in the same cycle as frame_done; during failsafe, ch_out SHALL hold its last values.

Reset
REQ-031 While rst=0: ch_out=0, history=0, staging=0, frame_done=0, failsafe=1, err_cnt=0, FSM=HUNT, chi=0, us_cnt=0, prescaler=0, loss counter=0, synchronizer and edge flops = idle level (~RISE_EDGE).
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no commit and no err_cnt change; after release, the first sync gap is required before capture.

Verification
REQ-033 CLK_PER_US=1, NUM_CH=6: sync 6000, pulses 1500,1200,1800,1000,2000,1400, sync; repeat x3 -> frame_done on each commit, ch_out settles to {500,200,800,0,999,400}, failsafe=0 after the first commit.
REQ-034 Median test: identical frames with ch0 = 1100,1900,1300 -> after the third commit, ch0 = 300 (median of 100,900,300).
REQ-035 Short frame (5 pulses, then sync) -> err_cnt+1, no frame_done, ch_out unchanged; next full frame commits normally.
REQ-036 Seven pulses before sync -> err_cnt+1, FSM=HUNT; next sync plus full frame commits.
REQ-037 No edges for TIMEOUT_US after a commit -> failsafe=1 exactly at the TIMEOUT_US tick, ch_out held; next commit -> failsafe=0.
REQ-038 rst=0 during the 3rd pulse -> all outputs at reset values next cycle; err_cnt stays 0.
